// File: rtl/ring_pos_to_remote_packer.sv
// Packs ring to-remote packets 4 per 512-bit AXI-Stream beat, then flushes a partial beat and sends an all-ones tlast terminator.
// Latency: beat valid the cycle after its 4th packet; partial beats flush after FLUSH_TIMEOUT idle cycles; registered back pressure from FIFO fill.
module ring_pos_to_remote_packer #(
  parameter int OFFSET_PKT_STRUCT_WIDTH = 80,
  parameter int GLOBAL_CELL_ID_WIDTH    = 3,
  parameter int NB_CELL_COUNT_WIDTH     = 5,
  parameter int AXIS_TDATA_WIDTH        = 512,
  parameter int OUT_FIFO_DEPTH          = 8,
  parameter int FLUSH_TIMEOUT           = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [OFFSET_PKT_STRUCT_WIDTH-1:0]    i_offset_pkt,
  input  logic [3*GLOBAL_CELL_ID_WIDTH-1:0]     i_gcid,
  input  logic [NB_CELL_COUNT_WIDTH-1:0]        i_lifetime,
  input  logic                                  i_valid,
  input  logic                                  i_iter_start,
  input  logic                                  i_iter_done,
  output logic                                  o_back_pressure,
  output logic [AXIS_TDATA_WIDTH-1:0]           o_tdata,
  output logic                                  o_tvalid,
  input  logic                                  i_tready,
  output logic                                  o_tlast,
  output logic                                  o_last_transfer_sent,
  output logic                                  o_overflow
);
  localparam int SLOT_W = AXIS_TDATA_WIDTH / 4;
  localparam int GCID_W = 3 * GLOBAL_CELL_ID_WIDTH;
  localparam int PAY_W  = OFFSET_PKT_STRUCT_WIDTH + GCID_W + NB_CELL_COUNT_WIDTH;
  localparam int PTR_W  = $clog2(OUT_FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TMR_W  = $clog2(FLUSH_TIMEOUT + 1);

  typedef struct packed {
    logic [SLOT_W-PAY_W-1:0]           zero;
    logic [NB_CELL_COUNT_WIDTH-1:0]    lifetime;
    logic [GCID_W-1:0]                 gcid;
    logic [OFFSET_PKT_STRUCT_WIDTH-1:0] pkt;
  } slot_t;

  typedef enum logic [1:0] {S_ACCUM, S_FLUSH, S_TERM, S_DONE} state_t;

  state_t                      r_state, w_state_nxt;
  slot_t                       r_slot [3];
  logic [1:0]                  r_cnt, w_cnt_nxt;
  logic [TMR_W-1:0]            r_tmr, w_tmr_nxt;
  logic [AXIS_TDATA_WIDTH-1:0] r_mem_dat [OUT_FIFO_DEPTH];
  logic                        r_mem_last [OUT_FIFO_DEPTH];
  logic [PTR_W-1:0]            r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]            r_count, w_count_nxt;
  logic                        r_bp, r_overflow;

  slot_t                       w_slot_new;
  logic [AXIS_TDATA_WIDTH-1:0] w_partial, w_full_beat, w_push_dat;
  logic                        w_empty, w_full, w_pop, w_can_push;
  logic                        w_push, w_push_last, w_slot_wr, w_ovf_set;

  always_comb begin
    w_slot_new          = '0;
    w_slot_new.lifetime = i_lifetime;
    w_slot_new.gcid     = i_gcid;
    w_slot_new.pkt      = i_offset_pkt;
  end

  // Unfilled slots read as all ones so the far end can skip them.
  always_comb begin
    w_partial = '1;
    for (int k = 0; k < 3; k++)
      if (k < int'(r_cnt)) w_partial[k*SLOT_W +: SLOT_W] = r_slot[k];
  end

  assign w_full_beat = {w_slot_new, r_slot[2], r_slot[1], r_slot[0]};
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_W'(OUT_FIFO_DEPTH));
  assign w_pop       = !w_empty && i_tready;
  assign w_can_push  = !w_full || w_pop;

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_push_dat  = w_partial;
    w_push_last = 1'b0;
    w_slot_wr   = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_tmr_nxt   = r_tmr;
    w_ovf_set   = 1'b0;
    case (r_state)
      S_ACCUM: begin
        if (i_valid) begin
          w_tmr_nxt = '0;
          if (r_cnt == 2'd3) begin
            w_cnt_nxt  = '0;
            w_push_dat = w_full_beat;
            w_push     = w_can_push;
            w_ovf_set  = !w_can_push;
          end else begin
            w_slot_wr = 1'b1;
            w_cnt_nxt = r_cnt + 2'd1;
          end
        end else if (r_cnt != '0) begin
          if (r_tmr >= TMR_W'(FLUSH_TIMEOUT - 1)) begin
            if (w_can_push) begin
              w_push    = 1'b1;
              w_cnt_nxt = '0;
              w_tmr_nxt = '0;
            end else begin
              w_tmr_nxt = TMR_W'(FLUSH_TIMEOUT);
            end
          end else begin
            w_tmr_nxt = r_tmr + TMR_W'(1);
          end
        end
        if (i_iter_done) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        w_tmr_nxt = '0;
        if (r_cnt == '0) begin
          w_state_nxt = S_TERM;
        end else if (w_can_push) begin
          w_push      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_TERM;
        end
      end
      S_TERM: begin
        if (w_can_push) begin
          w_push      = 1'b1;
          w_push_dat  = '1;
          w_push_last = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        if (i_iter_start) w_state_nxt = S_ACCUM;
      end
    endcase
  end

  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_ACCUM;
      r_cnt      <= '0;
      r_tmr      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_bp       <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tmr      <= w_tmr_nxt;
      r_count    <= w_count_nxt;
      r_bp       <= (w_count_nxt >= CNT_W'(OUT_FIFO_DEPTH - 2));
      r_overflow <= r_overflow | w_ovf_set;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem_dat[r_wr_ptr]  <= w_push_dat;
      r_mem_last[r_wr_ptr] <= w_push_last;
    end
    if (!rst && w_slot_wr) r_slot[r_cnt] <= w_slot_new;
  end

  assign o_tvalid             = !w_empty;
  assign o_tdata              = w_empty ? '1 : r_mem_dat[r_rd_ptr];
  assign o_tlast              = !w_empty && r_mem_last[r_rd_ptr];
  assign o_last_transfer_sent = w_pop && r_mem_last[r_rd_ptr];
  assign o_back_pressure      = r_bp;
  assign o_overflow           = r_overflow;
endmodule

// File: tb/tb_ring_pos_to_remote_packer.sv
// Directed bench for ring_pos_to_remote_packer: packing, timeout flush, back pressure, terminator, overflow, reset.
module tb_ring_pos_to_remote_packer;
  logic         clk = 1'b0;
  logic         rst;
  logic [79:0]  i_offset_pkt;
  logic [8:0]   i_gcid;
  logic [4:0]   i_lifetime;
  logic         i_valid, i_iter_start, i_iter_done, i_tready;
  logic         o_back_pressure, o_tvalid, o_tlast, o_last_transfer_sent, o_overflow;
  logic [511:0] o_tdata;

  int n_vec = 0;
  int n_err = 0;
  int n_pulse = 0;
  logic [127:0] ones128;
  logic [511:0] ones512;

  ring_pos_to_remote_packer dut (
    .clk(clk), .rst(rst), .i_offset_pkt(i_offset_pkt), .i_gcid(i_gcid),
    .i_lifetime(i_lifetime), .i_valid(i_valid), .i_iter_start(i_iter_start),
    .i_iter_done(i_iter_done), .o_back_pressure(o_back_pressure), .o_tdata(o_tdata),
    .o_tvalid(o_tvalid), .i_tready(i_tready), .o_tlast(o_tlast),
    .o_last_transfer_sent(o_last_transfer_sent), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (o_last_transfer_sent === 1'b1) n_pulse++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [127:0] slot(input logic [79:0] p, input logic [8:0] g, input logic [4:0] l);
    return {34'h0, l, g, p};
  endfunction

  function automatic logic [79:0] pk_n(input int m); return 80'(32'h1000 + m); endfunction
  function automatic logic [8:0]  gc_n(input int m); return 9'(m * 3); endfunction
  function automatic logic [4:0]  lt_n(input int m); return 5'(m); endfunction

  function automatic logic [511:0] beat_exp(input int j);
    logic [511:0] e;
    for (int s = 0; s < 4; s++) e[s*128 +: 128] = slot(pk_n(4*j+s), gc_n(4*j+s), lt_n(4*j+s));
    return e;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [79:0] p, input logic [8:0] g, input logic [4:0] l);
    i_valid = 1'b1; i_offset_pkt = p; i_gcid = g; i_lifetime = l;
    step();
    i_valid = 1'b0;
  endtask

  task automatic send_n(input int m);
    send(pk_n(m), gc_n(m), lt_n(m));
  endtask

  task automatic test_reset;
    rst = 1'b1; i_valid = 1'b0; i_iter_start = 1'b0; i_iter_done = 1'b0; i_tready = 1'b0;
    i_offset_pkt = '0; i_gcid = '0; i_lifetime = '0;
    step(); step();
    n_vec++; if (o_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b want 0", o_tvalid); end
    n_vec++; if (o_tlast !== 1'b0) begin n_err++; $display("FAIL rst_tlast: got %b want 0", o_tlast); end
    n_vec++; if (o_last_transfer_sent !== 1'b0) begin n_err++; $display("FAIL rst_last_sent: got %b want 0", o_last_transfer_sent); end
    n_vec++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b want 0", o_overflow); end
    n_vec++; if (o_back_pressure !== 1'b0) begin n_err++; $display("FAIL rst_bp: got %b want 0", o_back_pressure); end
    n_vec++; if (o_tdata !== ones512) begin n_err++; $display("FAIL rst_tdata: got %h want all ones", o_tdata); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_full_beat;
    logic [511:0] e;
    i_tready = 1'b1;
    for (int k = 0; k < 4; k++) e[k*128 +: 128] = slot(80'(k+1), 9'd0, 5'd3);
    for (int k = 0; k < 4; k++) begin
      send(80'(k+1), 9'd0, 5'd3);
      if (k < 3) begin
        n_vec++; if (o_tvalid !== 1'b0) begin n_err++; $display("FAIL full_early_tvalid pkt%0d: got %b want 0", k, o_tvalid); end
      end
    end
    n_vec++; if (o_tvalid !== 1'b1) begin n_err++; $display("FAIL full_tvalid: got %b want 1", o_tvalid); end
    n_vec++; if (o_tdata !== e) begin n_err++; $display("FAIL full_tdata: got %h want %h", o_tdata, e); end
    n_vec++; if (o_tlast !== 1'b0) begin n_err++; $display("FAIL full_tlast: got %b want 0", o_tlast); end
    step();
    n_vec++; if (o_tvalid !== 1'b0) begin n_err++; $display("FAIL full_popped: got %b want 0", o_tvalid); end
  endtask

  task automatic test_timeout;
    logic [511:0] e;
    i_tready = 1'b1;
    e = {ones128, ones128, ones128, slot(80'h55, 9'h1AB, 5'd7)};
    send(80'h55, 9'h1AB, 5'd7);
    for (int i = 1; i <= 15; i++) begin
      step();
      n_vec++; if (o_tvalid !== 1'b0) begin n_err++; $display("FAIL tmo_early idle%0d: got %b want 0", i, o_tvalid); end
    end
    step();
    n_vec++; if (o_tvalid !== 1'b1) begin n_err++; $display("FAIL tmo_tvalid: got %b want 1", o_tvalid); end
    n_vec++; if (o_tdata !== e) begin n_err++; $display("FAIL tmo_tdata: got %h want %h", o_tdata, e); end
    step();
  endtask

  task automatic test_timeout_race;
    logic [511:0] e;
    i_tready = 1'b1;
    e = {ones128, ones128, slot(80'hB2, 9'h0B2, 5'd2), slot(80'hA1, 9'h0A1, 5'd1)};
    send(80'hA1, 9'h0A1, 5'd1);
    repeat (15) step();
    send(80'hB2, 9'h0B2, 5'd2);
    n_vec++; if (o_tvalid !== 1'b0) begin n_err++; $display("FAIL race_no_flush: got %b want 0", o_tvalid); end
    repeat (15) step();
    n_vec++; if (o_tvalid !== 1'b0) begin n_err++; $display("FAIL race_restart: got %b want 0", o_tvalid); end
    step();
    n_vec++; if (o_tvalid !== 1'b1) begin n_err++; $display("FAIL race_tvalid: got %b want 1", o_tvalid); end
    n_vec++; if (o_tdata !== e) begin n_err++; $display("FAIL race_tdata: got %h want %h", o_tdata, e); end
    step();
  endtask

  task automatic test_back_to_back;
    int n;
    i_tready = 1'b0;
    n = 0;
    while (n < 40 && o_back_pressure !== 1'b1) begin
      i_valid = 1'b1; i_offset_pkt = pk_n(n); i_gcid = gc_n(n); i_lifetime = lt_n(n);
      step();
      n++;
      n_vec++; if (o_back_pressure !== (n >= 24)) begin n_err++; $display("FAIL bp_level pkts=%0d: got %b want %b", n, o_back_pressure, (n >= 24)); end
    end
    i_valid = 1'b0;
    n_vec++; if (n !== 24) begin n_err++; $display("FAIL bp_pkts_sent: got %0d want 24", n); end
    step();
    n_vec++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL bp_overflow: got %b want 0", o_overflow); end
    n_vec++; if (o_back_pressure !== 1'b1) begin n_err++; $display("FAIL bp_hold: got %b want 1", o_back_pressure); end
    i_tready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      n_vec++; if (o_tdata !== beat_exp(j) || o_tvalid !== 1'b1) begin n_err++; $display("FAIL bp_drain beat%0d: got %h want %h", j, o_tdata, beat_exp(j)); end
      step();
    end
    n_vec++; if (o_tvalid !== 1'b0) begin n_err++; $display("FAIL bp_drained: got %b want 0", o_tvalid); end
    n_vec++; if (o_back_pressure !== 1'b0) begin n_err++; $display("FAIL bp_release: got %b want 0", o_back_pressure); end
  endtask

  task automatic test_iter_done;
    logic [511:0] e;
    int p0;
    p0 = n_pulse;
    i_tready = 1'b0;
    e = {ones128, ones128, slot(80'hD2, 9'h0D2, 5'd9), slot(80'hD1, 9'h0D1, 5'd8)};
    send(80'hD1, 9'h0D1, 5'd8);
    send(80'hD2, 9'h0D2, 5'd9);
    i_iter_done = 1'b1;
    step();
    i_iter_done = 1'b0;
    step(); step(); step();
    n_vec++; if (o_tdata !== e || o_tvalid !== 1'b1) begin n_err++; $display("FAIL done_partial: got %h want %h", o_tdata, e); end
    n_vec++; if (o_tlast !== 1'b0) begin n_err++; $display("FAIL done_partial_tlast: got %b want 0", o_tlast); end
    i_tready = 1'b1;
    #1;
    n_vec++; if (o_last_transfer_sent !== 1'b0) begin n_err++; $display("FAIL done_early_sent: got %b want 0", o_last_transfer_sent); end
    step();
    n_vec++; if (o_tdata !== ones512 || o_tvalid !== 1'b1) begin n_err++; $display("FAIL done_term_tdata: got %h want all ones", o_tdata); end
    n_vec++; if (o_tlast !== 1'b1) begin n_err++; $display("FAIL done_term_tlast: got %b want 1", o_tlast); end
    n_vec++; if (o_last_transfer_sent !== 1'b1) begin n_err++; $display("FAIL done_sent: got %b want 1", o_last_transfer_sent); end
    step();
    n_vec++; if (o_tvalid !== 1'b0) begin n_err++; $display("FAIL done_empty: got %b want 0", o_tvalid); end
    i_tready = 1'b0;
    for (int m = 0; m < 4; m++) send_n(100 + m);
    repeat (20) step();
    n_vec++; if (o_tvalid !== 1'b0) begin n_err++; $display("FAIL done_ignores_valid: got %b want 0", o_tvalid); end
    i_iter_start = 1'b1;
    step();
    i_iter_start = 1'b0;
    for (int m = 0; m < 4; m++) send_n(100 + m);
    n_vec++; if (o_tdata !== beat_exp(25) || o_tvalid !== 1'b1) begin n_err++; $display("FAIL done_restart: got %h want %h", o_tdata, beat_exp(25)); end
    i_tready = 1'b1;
    step();
    n_vec++; if (n_pulse - p0 !== 1) begin n_err++; $display("FAIL done_pulse_count: got %0d want 1", n_pulse - p0); end
  endtask

  task automatic test_overflow;
    i_tready = 1'b0;
    for (int m = 0; m < 32; m++) send_n(m);
    n_vec++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_full_ok: got %b want 0", o_overflow); end
    for (int m = 32; m < 36; m++) send_n(m);
    n_vec++; if (o_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", o_overflow); end
    i_tready = 1'b1;
    n_vec++; if (o_tdata !== beat_exp(0)) begin n_err++; $display("FAIL ovf_head: got %h want %h", o_tdata, beat_exp(0)); end
    repeat (7) step();
    n_vec++; if (o_tdata !== beat_exp(7)) begin n_err++; $display("FAIL ovf_tail: got %h want %h", o_tdata, beat_exp(7)); end
    step();
    n_vec++; if (o_tvalid !== 1'b0) begin n_err++; $display("FAIL ovf_dropped: got %b want 0", o_tvalid); end
    n_vec++; if (o_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", o_overflow); end
  endtask

  task automatic test_reset_mid;
    logic seen;
    int p0;
    i_tready = 1'b0;
    for (int m = 0; m < 11; m++) send_n(m);
    n_vec++; if (o_tvalid !== 1'b1) begin n_err++; $display("FAIL rmid_queued: got %b want 1", o_tvalid); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++; if (o_tvalid !== 1'b0) begin n_err++; $display("FAIL rmid_tvalid: got %b want 0", o_tvalid); end
    n_vec++; if (o_tdata !== ones512) begin n_err++; $display("FAIL rmid_tdata: got %h want all ones", o_tdata); end
    n_vec++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL rmid_overflow: got %b want 0", o_overflow); end
    p0 = n_pulse;
    seen = 1'b0;
    i_tready = 1'b1;
    repeat (25) begin
      step();
      if (o_tvalid === 1'b1) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rmid_no_beat: got %b want 0", seen); end
    n_vec++; if (n_pulse - p0 !== 0) begin n_err++; $display("FAIL rmid_no_term: got %0d want 0", n_pulse - p0); end
    i_tready = 1'b0;
    for (int m = 0; m < 4; m++) send_n(m);
    n_vec++; if (o_tdata !== beat_exp(0) || o_tvalid !== 1'b1) begin n_err++; $display("FAIL rmid_clean: got %h want %h", o_tdata, beat_exp(0)); end
    n_vec++; if (o_tlast !== 1'b0) begin n_err++; $display("FAIL rmid_clean_tlast: got %b want 0", o_tlast); end
  endtask

  initial begin
    ones128 = '1;
    ones512 = '1;
    test_reset();
    test_full_beat();
    test_timeout();
    test_timeout_race();
    test_back_to_back();
    test_iter_done();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
